controlador_sync_vga: RTL

//  Timing master for the 640x480@60 Hz text display. Divides the system clock into a

---
 rtl/controlador_sync_vga.sv | 113 +++++++++++
 1 files changed

// File: rtl/controlador_sync_vga.sv
// controlador_sync_vga: 640x480@60 Hz scan timing master.
// Divides reloj into a pixel tick, sequences the Qh/Qv scan counters and
// produces hsync, vsync, video_on and a frame-start pulse.
// Optional build macro VGA_FRAME_CNT_EN adds the 8-bit cuadro_cnt frame counter.
module controlador_sync_vga #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned CLK_DIV   = 4
) (
  input  logic       reloj,
  input  logic       reset,
  input  logic       habilitar,
  output logic [9:0] Qh,
  output logic [9:0] Qv,
  output logic       tick_pixel,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       fin_cuadro
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0] cuadro_cnt
`endif
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;
  logic [CNT_W-1:0] qh_next;
  logic [CNT_W-1:0] qv_next;
  logic             avanza;
  logic             h_wrap;
  logic             v_wrap;
  logic             frame_wrap;

  // Next-state of divider and scan counters; counters step when div is at its last count.
  always_comb begin
    div_next   = div;
    qh_next    = Qh;
    qv_next    = Qv;
    avanza     = habilitar && (div == DIV_LAST);
    h_wrap     = (Qh == H_LAST);
    v_wrap     = (Qv == V_LAST);
    frame_wrap = avanza && h_wrap && v_wrap;
    if (habilitar) begin
      div_next = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end
    if (avanza) begin
      if (h_wrap) begin
        qh_next = '0;
        qv_next = v_wrap ? '0 : Qv + CNT_W'(1);
      end else begin
        qh_next = Qh + CNT_W'(1);
      end
    end
  end

  // Timing state; syncs and video_on are decoded from the next counter values so
  // they switch on the same edge as Qh/Qv.
  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      div        <= '0;
      Qh         <= '0;
      Qv         <= '0;
      tick_pixel <= 1'b0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      video_on   <= 1'b1;
      fin_cuadro <= 1'b0;
    end else begin
      div        <= div_next;
      Qh         <= qh_next;
      Qv         <= qv_next;
      tick_pixel <= habilitar && (div_next == DIV_LAST);
      hsync      <= !((qh_next >= HS_START) && (qh_next < HS_END));
      vsync      <= !((qv_next >= VS_START) && (qv_next < VS_END));
      video_on   <= (qh_next < H_VIS) && (qv_next < V_VIS);
      fin_cuadro <= frame_wrap;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Frame counter for cursor blink / animation, steps with each frame wrap.
  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      cuadro_cnt <= '0;
    end else if (frame_wrap) begin
      cuadro_cnt <= cuadro_cnt + 8'd1;
    end
  end
`endif

endmodule
